// File: rtl/clkctrl_pkg.sv
// Shared types and constants for the clkctrl_sched clock-enable / reset sequencer.
package clkctrl_pkg;

  localparam int unsigned HOLD_W    = 16;
  localparam int unsigned DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StRun   = 2'd1,
    StApply = 2'd2
  } state_e;

endpackage

// File: rtl/clkctrl_en_gen.sv
// Divide counter and registered clock-enable strobe: one clk_en per div_reg+1 cycles.
// pause freezes the counter; load restarts the period from zero with no strobe.
module clkctrl_en_gen
  import clkctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_reg,
  input  logic             pause,
  input  logic             load,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;

  always_comb begin
    cnt_d    = cnt_q;
    clk_en_d = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (!pause) begin
      // >= keeps the counter bounded even if the ratio ever shrinks under it
      if (cnt_q >= div_reg) begin
        cnt_d    = '0;
        clk_en_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en = clk_en_q;

endmodule

// File: rtl/clkctrl_sched.sv
// Clock-enable scheduler: runtime divide-ratio handshake and sequenced resetn release.
// Define CLKCTRL_RST_ON_CHANGE_EN to re-run the reset hold after every ratio change.
module clkctrl_sched
  import clkctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DIV_DEFAULT = 0,
  parameter int unsigned RST_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_busy,
  input  logic             pause,
  output logic             clk_en,
  output logic             resetn
);

  localparam logic [DIV_W-1:0]  DivRst  = DIV_W'(DIV_DEFAULT);
  localparam logic [HOLD_W-1:0] RstMax  = HOLD_W'(RST_CYCLES);
  localparam logic [HOLD_W-1:0] RstLast = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [DIV_W-1:0]  div_reg_q, div_reg_d;
  logic [DIV_W-1:0]  pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              resetn_q, resetn_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic load;
  logic hold_tick;
  logic hold_done;
  logic boundary;
  logic capture;

  clkctrl_en_gen #(
    .DIV_W (DIV_W)
  ) u_en_gen (
    .clk     (clk),
    .reset   (reset),
    .div_reg (div_reg_q),
    .pause   (pause),
    .load    (load),
    .clk_en  (clk_en)
  );

  // A strobe seen while paused is not a period boundary and does not count toward the hold.
  assign hold_tick = (state_q == StHold) && clk_en && !pause && (hold_cnt_q != RstMax);
  assign hold_done = hold_tick && (hold_cnt_q == RstLast);
  assign boundary  = (state_q != StApply) && busy_q && clk_en && !pause;
  assign capture   = (state_q != StApply) && div_req && !busy_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    div_reg_d  = div_reg_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    resetn_d   = resetn_q;
    hold_cnt_d = hold_cnt_q;
    load       = 1'b0;

    if (hold_tick) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    if (hold_done) begin
      resetn_d = 1'b1;
      state_d  = StRun;
    end

    unique case (state_q)
      StHold, StRun: begin
        if (capture) begin
          pend_d = div_val;
          busy_d = 1'b1;
        end
        if (boundary) begin
          load      = 1'b1;
          div_reg_d = pend_q;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
          state_d   = StApply;
`ifdef CLKCTRL_RST_ON_CHANGE_EN
          ret_d      = StHold;
          resetn_d   = 1'b0;
          hold_cnt_d = '0;
`else
          // A release coinciding with the boundary must still land in RUN after APPLY.
          ret_d = hold_done ? StRun : state_q;
`endif
        end
      end
      StApply: begin
        state_d = ret_q;
      end
      default: begin
        state_d = StHold;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHold;
      ret_q      <= StHold;
      div_reg_q  <= DivRst;
      pend_q     <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      resetn_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      div_reg_q  <= div_reg_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      resetn_q   <= resetn_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign div_ack  = ack_q;
  assign div_busy = busy_q;
  assign resetn   = resetn_q;

endmodule

// File: tb/tb_clkctrl_sched.sv
// Scoreboard bench for clkctrl_sched (DIV_DEFAULT=3, RST_CYCLES=4): per-cycle expected
// {clk_en, resetn, div_ack, div_busy} vectors are queued with the stimulus and popped per cycle.
module tb_clkctrl_sched;

  localparam int unsigned DivW   = 8;
  localparam int unsigned DivDef = 3;
  localparam int unsigned RstCyc = 4;
`ifdef CLKCTRL_RST_ON_CHANGE_EN
  localparam bit RstOnChange = 1'b1;
`else
  localparam bit RstOnChange = 1'b0;
`endif
  // resetn after a ratio change is only predictable here in the default build
  localparam logic [3:0] MaskLate = RstOnChange ? 4'b1011 : 4'b1111;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            div_req = 1'b0;
  logic [DivW-1:0] div_val = '0;
  logic            pause = 1'b0;
  logic            div_ack, div_busy, clk_en, resetn;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] v;
    logic [3:0] mask;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  clkctrl_sched #(
    .DIV_W       (DivW),
    .DIV_DEFAULT (DivDef),
    .RST_CYCLES  (RstCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .div_req  (div_req),
    .div_val  (div_val),
    .div_ack  (div_ack),
    .div_busy (div_busy),
    .pause    (pause),
    .clk_en   (clk_en),
    .resetn   (resetn)
  );

  function automatic logic [3:0] obs();
    return {clk_en, resetn, div_ack, div_busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int c, input logic en, input logic rn, input logic ack,
                      input logic busy, input logic [3:0] mask);
    exp_t e;
    e.cyc  = c;
    e.v    = {en, rn, ack, busy};
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int n);
    for (int c = 1; c <= n; c++) begin
      push(c, (c % (DivDef + 1)) == 0, c >= 17, 1'b0, 1'b0, 4'b1111);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs() !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset[%0d]: en/rn/ack/busy got %b want 0000", i, obs());
      end
    end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset_to_run();
    exp_t e;
    push_run(20);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL reset_to_run cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
    end
  endtask

  task automatic test_div_change();
    exp_t e;
    div_req = 1'b1;
    div_val = 8'd1;
    for (int c = 21; c <= 32; c++) begin
      push(c, (c == 24) || (c >= 27 && (c % 2) == 1),
           RstOnChange ? (c < 25 || c >= 34) : 1'b1,
           c == 25, c >= 21 && c <= 24, 4'b1111);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL div_change cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 25) div_req = 1'b0;
    end
  endtask

  task automatic test_req_at_boundary();
    exp_t e;
    push(33, 1'b1, 1'b1, 1'b0, 1'b0, MaskLate);
    for (int c = 34; c <= 44; c++) begin
      push(c, c == 35 || c == 40 || c == 44, 1'b1, c == 36, c == 34 || c == 35, MaskLate);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL req_at_boundary cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 33) begin
        div_req = 1'b1;
        div_val = 8'd3;
      end
      if (cyc == 36) div_req = 1'b0;
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    div_req = 1'b1;
    div_val = 8'd0;
    for (int c = 45; c <= 56; c++) begin
      push(c, c == 48 || c >= 50, 1'b1, c == 49, c >= 45 && c <= 48, MaskLate);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL div_zero cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 49) div_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Change 0 -> 3 while strobing every cycle: boundary is the very next cycle.
    div_req = 1'b1;
    div_val = 8'd3;
    for (int c = 57; c <= 62; c++) begin
      push(c, c == 57 || c == 62, 1'b1, c == 58, c == 57, MaskLate);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 58) div_req = 1'b0;
    end
  endtask

  task automatic test_pause();
    exp_t e;
    // cnt is 2 in cycle 64; five paused edges push the strobe from 66 to 71.
    for (int c = 63; c <= 72; c++) begin
      push(c, c == 71, 1'b1, 1'b0, 1'b0, MaskLate);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL pause cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 64) pause = 1'b1;
      if (cyc == 69) pause = 1'b0;
    end
  endtask

  task automatic test_pause_pending();
    exp_t e;
    div_req = 1'b1;
    div_val = 8'd1;
    // Pause covers the boundary strobe at 75, so the apply waits for the strobe at 82.
    for (int c = 73; c <= 87; c++) begin
      push(c, c == 75 || c == 82 || c == 85 || c == 87, 1'b1, c == 83,
           c >= 73 && c <= 82, MaskLate);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL pause_pending cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 75) pause = 1'b1;
      if (cyc == 78) pause = 1'b0;
      if (cyc == 83) div_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    div_req = 1'b1;
    div_val = 8'd5;
    push(88, 1'b0, 1'b1, 1'b0, 1'b1, MaskLate);
    push(89, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.v & e.mask)) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
      if (cyc == 88) begin
        reset   = 1'b1;
        div_req = 1'b0;
      end
    end
    reset = 1'b0;
    cyc = 0;
    // Ratio must be back at DIV_DEFAULT, hold re-run, and the dropped request never acked.
    push_run(20);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL reset_mid_rerun cyc %0d: got %b want %b", e.cyc, obs(), e.v);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_to_run();
    test_div_change();
    test_req_at_boundary();
    test_div_zero();
    test_back_to_back();
    test_pause();
    test_pause_pending();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
